// File: rtl/game_display.sv
// Dice game status display: 7-segment glyphs for die/state/score/turns plus status LEDs.
// Latency: every output is registered, so an input change shows one clk cycle later.
// Backpressure: none; this is a pure sink of level inputs and drives displays continuously.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   num[2:0]          : die value (1..6; 0 and 7 show a dash)
//   score[3:0]        : player score, shown as two decimal digits on HEX3:HEX2
//   turns[3:0]        : turns taken, shown as two decimal digits on HEX5:HEX4
//   state[1:0]        : 0 START, 1 ROLL, 2 CHOOSE, 3 END (letter on HEX1)
//   won               : win flag, only looked at in END
//   HEX0..HEX5[7:0]   : active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//   LEDR[9:0]         : active-high status LEDs
// Optional feature: define GAME_DISPLAY_ANIM_EN to get a rotating chaser on LEDR
// when the game ends in a win; without it the win shows all LEDs lit steadily.
module game_display #(
  parameter int TICK_DIV  = 25000000,
  parameter int ANIM_STEP = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] num,
  input  logic [3:0] score,
  input  logic [3:0] turns,
  input  logic [1:0] state,
  input  logic       won,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [9:0] LEDR
);

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_CHOOSE = 2'd2;
  localparam logic [1:0] ST_END    = 2'd3;
  localparam logic [7:0] GL_BLANK  = 8'hFF;
  localparam logic [7:0] GL_DASH   = 8'hBF;
  localparam int         TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  function automatic logic [7:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    f_glyph = 8'hC0;
      4'd1:    f_glyph = 8'hF9;
      4'd2:    f_glyph = 8'hA4;
      4'd3:    f_glyph = 8'hB0;
      4'd4:    f_glyph = 8'h99;
      4'd5:    f_glyph = 8'h92;
      4'd6:    f_glyph = 8'h82;
      4'd7:    f_glyph = 8'hF8;
      4'd8:    f_glyph = 8'h80;
      4'd9:    f_glyph = 8'h90;
      default: f_glyph = GL_BLANK;
    endcase
  endfunction

  logic [1:0]    r_prev_state;
  logic [TW-1:0] r_tick;
  logic          r_vis;
  logic [7:0]    r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
  logic [9:0]    r_ledr;

  logic          w_state_chg;
  logic [TW-1:0] w_tick_nxt;
  logic          w_vis_nxt;
  logic [7:0]    w_hex0, w_hex1, w_hex2, w_hex3, w_hex4, w_hex5;
  logic [9:0]    w_ledr;
  logic [9:0]    w_win_led;

  // Blink timebase. Outputs use the phase being loaded this cycle, so the
  // state-change cycle itself is the first of TICK_DIV visible cycles.
  always_comb begin
    w_state_chg = (state != r_prev_state);
    w_tick_nxt  = r_tick + 1'b1;
    w_vis_nxt   = r_vis;
    if (w_state_chg) begin
      w_tick_nxt = '0;
      w_vis_nxt  = 1'b1;
    end else if (r_tick == TW'(TICK_DIV - 1)) begin
      w_tick_nxt = '0;
      w_vis_nxt  = ~r_vis;
    end
  end

`ifdef GAME_DISPLAY_ANIM_EN
  localparam int SW = (ANIM_STEP > 2) ? $clog2(ANIM_STEP) : 1;

  logic [SW-1:0] r_step;
  logic [9:0]    r_pos;
  logic          r_prev_won;
  logic [SW-1:0] w_step_nxt;
  logic [9:0]    w_pos_nxt;

  // Chaser restarts on entering END or on a fresh win inside END, and sits
  // at its reset position whenever the game is not in END.
  always_comb begin
    w_step_nxt = r_step + 1'b1;
    w_pos_nxt  = r_pos;
    if (state != ST_END ||
        r_prev_state != ST_END || (won && !r_prev_won)) begin
      w_step_nxt = '0;
      w_pos_nxt  = 10'd1;
    end else if (r_step == SW'(ANIM_STEP - 1)) begin
      w_step_nxt = '0;
      w_pos_nxt  = {r_pos[8:0], r_pos[9]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step     <= '0;
      r_pos      <= 10'd1;
      r_prev_won <= 1'b0;
    end else begin
      r_step     <= w_step_nxt;
      r_pos      <= w_pos_nxt;
      r_prev_won <= won;
    end
  end

  assign w_win_led = w_pos_nxt;
`else
  assign w_win_led = 10'h3FF;
`endif

  always_comb begin
    w_hex0 = (num == 3'd0 || num == 3'd7) ? GL_DASH : f_glyph({1'b0, num});
    if (state == ST_CHOOSE && !w_vis_nxt) w_hex0 = GL_BLANK;
    case (state)
      2'd0:    w_hex1 = 8'h8C;
      2'd1:    w_hex1 = 8'hAF;
      2'd2:    w_hex1 = 8'hC6;
      default: w_hex1 = 8'h86;
    endcase
    // Inputs top out at 15, so the tens digit is either blank or '1'.
    w_hex2 = f_glyph((score >= 4'd10) ? score - 4'd10 : score);
    w_hex3 = (score >= 4'd10) ? f_glyph(4'd1) : GL_BLANK;
    w_hex4 = f_glyph((turns >= 4'd10) ? turns - 4'd10 : turns);
    w_hex5 = (turns >= 4'd10) ? f_glyph(4'd1) : GL_BLANK;
    if (state != ST_END)  w_ledr = 10'd1 << state;
    else if (!won)        w_ledr = w_vis_nxt ? 10'h3FF : 10'h000;
    else                  w_ledr = w_win_led;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_state <= ST_START;
      r_tick       <= '0;
      r_vis        <= 1'b1;
      r_hex0       <= GL_BLANK;
      r_hex1       <= GL_BLANK;
      r_hex2       <= GL_BLANK;
      r_hex3       <= GL_BLANK;
      r_hex4       <= GL_BLANK;
      r_hex5       <= GL_BLANK;
      r_ledr       <= '0;
    end else begin
      r_prev_state <= state;
      r_tick       <= w_tick_nxt;
      r_vis        <= w_vis_nxt;
      r_hex0       <= w_hex0;
      r_hex1       <= w_hex1;
      r_hex2       <= w_hex2;
      r_hex3       <= w_hex3;
      r_hex4       <= w_hex4;
      r_hex5       <= w_hex5;
      r_ledr       <= w_ledr;
    end
  end

  assign HEX0 = r_hex0;
  assign HEX1 = r_hex1;
  assign HEX2 = r_hex2;
  assign HEX3 = r_hex3;
  assign HEX4 = r_hex4;
  assign HEX5 = r_hex5;
  assign LEDR = r_ledr;

endmodule

// File: tb/tb_game_display.sv
module tb_game_display;
  localparam int TD = 4;
  localparam int AS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] num = '0;
  logic [3:0] score = '0;
  logic [3:0] turns = '0;
  logic [1:0] state = '0;
  logic       won = 1'b0;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  game_display #(.TICK_DIV(TD), .ANIM_STEP(AS)) dut (
    .clk(clk), .rst(rst), .num(num), .score(score), .turns(turns),
    .state(state), .won(won),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4),
    .HEX5(HEX5), .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] digit_gl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] letter_gl [4] = '{8'h8C, 8'hAF, 8'hC6, 8'h86};

  // Model: time since the blink / chaser last restarted, phases derived by division.
  int         m_k = 0;
  int         m_k2 = 0;
  logic [1:0] m_prev = 2'd0;
  logic       m_prev_won = 1'b0;
  logic [7:0] e_hex [6];
  logic [9:0] e_ledr;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] dec_ones(input logic [3:0] v);
    return digit_gl[int'(v) % 10];
  endfunction

  function automatic logic [7:0] dec_tens(input logic [3:0] v);
    return (v < 10) ? 8'hFF : digit_gl[int'(v) / 10];
  endfunction

  task automatic model_edge();
    bit vis;
    if (rst) begin
      m_k = 0; m_k2 = 0; m_prev = 2'd0; m_prev_won = 1'b0;
      for (int i = 0; i < 6; i++) e_hex[i] = 8'hFF;
      e_ledr = 10'h000;
      return;
    end
    if (state != m_prev) m_k = 0;
    else m_k = (m_k + 1) % (2 * TD);
    if (state == 2'd3 && (m_prev != 2'd3 || (won && !m_prev_won))) m_k2 = 0;
    else m_k2 = (m_k2 + 1) % (10 * AS);
    vis = ((m_k / TD) % 2) == 0;
    e_hex[0] = (num == 0 || num == 7) ? 8'hBF : digit_gl[num];
    if (state == 2'd2 && !vis) e_hex[0] = 8'hFF;
    e_hex[1] = letter_gl[state];
    e_hex[2] = dec_ones(score);
    e_hex[3] = dec_tens(score);
    e_hex[4] = dec_ones(turns);
    e_hex[5] = dec_tens(turns);
    if (state != 2'd3) e_ledr = 10'd1 << state;
    else if (!won) e_ledr = vis ? 10'h3FF : 10'h000;
    else begin
`ifdef GAME_DISPLAY_ANIM_EN
      e_ledr = 10'd1 << ((m_k2 / AS) % 10);
`else
      e_ledr = 10'h3FF;
`endif
    end
    m_prev = state;
    m_prev_won = won;
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("HEX0", {2'b0, HEX0}, {2'b0, e_hex[0]});
    check("HEX1", {2'b0, HEX1}, {2'b0, e_hex[1]});
    check("HEX2", {2'b0, HEX2}, {2'b0, e_hex[2]});
    check("HEX3", {2'b0, HEX3}, {2'b0, e_hex[3]});
    check("HEX4", {2'b0, HEX4}, {2'b0, e_hex[4]});
    check("HEX5", {2'b0, HEX5}, {2'b0, e_hex[5]});
    check("LEDR", LEDR, e_ledr);
  endtask

  initial begin
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hex0", {2'b0, HEX0}, 10'h0FF);
      check("rst_ledr", LEDR, 10'h000);
    end
    rst = 1'b0; state = 2'd0; num = 3'd3; score = 4'd12; turns = 4'd5;
    step();
    check("p_hex0", {2'b0, HEX0}, 10'h0B0);
    check("p_hex1", {2'b0, HEX1}, 10'h08C);
    check("p_hex3", {2'b0, HEX3}, 10'h0F9);
    check("p_hex2", {2'b0, HEX2}, 10'h0A4);
    check("p_hex5", {2'b0, HEX5}, 10'h0FF);
    check("p_hex4", {2'b0, HEX4}, 10'h092);
    check("p_ledr", LEDR, 10'h001);

    state = 2'd1; step();
    check("roll_ledr", LEDR, 10'h002);
    state = 2'd2; num = 3'd6;
    for (int i = 0; i < 16; i++) begin
      step();
      check("choose_blink", {2'b0, HEX0}, ((i / 4) % 2 == 0) ? 10'h082 : 10'h0FF);
      check("choose_ledr", LEDR, 10'h004);
    end

    num = 3'd7; step();
    check("dash_hex0", {2'b0, HEX0}, 10'h0BF);

    state = 2'd3; won = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("lose_ledr", LEDR, ((i / 4) % 2 == 0) ? 10'h3FF : 10'h000);
      check("end_hex1", {2'b0, HEX1}, 10'h086);
    end

    won = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
`ifdef GAME_DISPLAY_ANIM_EN
      check("win_chase", LEDR, 10'd1 << ((i / 2) % 10));
`else
      check("win_steady", LEDR, 10'h3FF);
`endif
    end

    // Reset pulse while HEX0 is blanked in CHOOSE.
    state = 2'd2; won = 1'b0; num = 3'd6;
    for (int i = 0; i < 5; i++) step();
    check("hidden_before_rst", {2'b0, HEX0}, 10'h0FF);
    rst = 1'b1; step();
    check("rst_pulse_hex1", {2'b0, HEX1}, 10'h0FF);
    check("rst_pulse_ledr", LEDR, 10'h000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_blink", {2'b0, HEX0}, (i < 4) ? 10'h082 : 10'h0FF);
    end

    // Randomised segments with held state so blink and chaser phases develop.
    for (int seg = 0; seg < 200; seg++) begin
      int hold;
      hold  = $urandom_range(1, 26);
      state = 2'($urandom_range(0, 3));
      won   = 1'($urandom_range(0, 1));
      num   = 3'($urandom_range(0, 7));
      score = 4'($urandom_range(0, 15));
      turns = 4'($urandom_range(0, 15));
      for (int c = 0; c < hold; c++) begin
        rst = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 5) == 0) num = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) score = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) turns = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) won = ~won;
        step();
      end
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
